// File: rtl/pwm_breath_ctrl.sv
// pwm_breath_ctrl: sequences the duty value for one PWM channel.
// It selects OFF, MANUAL-step or BREATH (automatic up/down ramp) operation.
// The duty value handed to the PWM datapath changes only on PWM period
// boundaries, so a running period is never truncated.
// Optional build macro: PWM_CTRL_SAT_EN
//   - MANUAL steps saturate at MAX instead of wrapping.
//   - Leaving MANUAL with the target at MAX enters BREATH_DOWN.
module pwm_breath_ctrl #(
  parameter int unsigned DW           = 3,
  parameter int unsigned STEP         = 1,
  parameter int unsigned HOLD_PERIODS = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_mode,
  input  logic          key_step,
  input  logic          period_end,
  output logic [DW-1:0] duty,
  output logic          duty_upd,
  output logic [1:0]    mode
);

  localparam int unsigned    HCW       = 16;
  localparam logic [DW-1:0]  MAX_V     = {DW{1'b1}};
  localparam logic [DW:0]    MAX_W     = {1'b0, MAX_V};
  localparam logic [DW:0]    STEP_W    = (DW+1)'(STEP);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_PERIODS - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_MANUAL = 2'b01,
    ST_UP     = 2'b10,
    ST_DOWN   = 2'b11
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  duty_nxt_q, duty_nxt_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [DW-1:0]  duty_d;
  logic           duty_upd_d;
  logic [DW:0]    sum_c;

  // Target plus one step, one bit wider so overflow is visible.
  assign sum_c = {1'b0, duty_nxt_q} + STEP_W;

  // Mode output is the state register itself.
  assign mode = state_q;

  // Next-state, target, hold counter and shadowed duty.
  always_comb begin
    state_d    = state_q;
    duty_nxt_d = duty_nxt_q;
    hold_d     = hold_q;
    duty_d     = duty;
    duty_upd_d = 1'b0;

    // Boundary load sees the target from before any step/transition this cycle.
    if (period_end && (duty != duty_nxt_q)) begin
      duty_d     = duty_nxt_q;
      duty_upd_d = 1'b1;
    end

    case (state_q)
      ST_OFF: begin
        if (key_mode) begin
          state_d    = ST_MANUAL;
          duty_nxt_d = '0;
          hold_d     = '0;
        end
      end

      ST_MANUAL: begin
        if (key_mode) begin
          // key_mode wins over a simultaneous key_step.
`ifdef PWM_CTRL_SAT_EN
          state_d = (duty_nxt_q == MAX_V) ? ST_DOWN : ST_UP;
`else
          state_d = ST_UP;
`endif
          hold_d = '0;
        end else if (key_step) begin
`ifdef PWM_CTRL_SAT_EN
          duty_nxt_d = (sum_c > MAX_W) ? MAX_V : sum_c[DW-1:0];
`else
          duty_nxt_d = sum_c[DW-1:0];
`endif
        end
      end

      ST_UP, ST_DOWN: begin
        if (key_mode) begin
          state_d    = ST_OFF;
          duty_nxt_d = '0;
          hold_d     = '0;
        end else if (period_end) begin
          if (hold_q >= HOLD_LAST) begin
            hold_d = '0;
            if (state_q == ST_UP) begin
              if (sum_c >= MAX_W) begin
                duty_nxt_d = MAX_V;
                state_d    = ST_DOWN;
              end else begin
                duty_nxt_d = sum_c[DW-1:0];
              end
            end else begin
              if ({1'b0, duty_nxt_q} <= STEP_W) begin
                duty_nxt_d = '0;
                state_d    = ST_UP;
              end else begin
                duty_nxt_d = duty_nxt_q - STEP_W[DW-1:0];
              end
            end
          end else begin
            hold_d = hold_q + HCW'(1);
          end
        end
      end

      default: begin
        state_d    = ST_OFF;
        duty_nxt_d = '0;
        hold_d     = '0;
      end
    endcase
  end

  // State and output registers; reset discards any pending update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_OFF;
      duty_nxt_q <= '0;
      hold_q     <= '0;
      duty       <= '0;
      duty_upd   <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_nxt_q <= duty_nxt_d;
      hold_q     <= hold_d;
      duty       <= duty_d;
      duty_upd   <= duty_upd_d;
    end
  end

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Directed bench for pwm_breath_ctrl (DW=3, STEP=1, HOLD_PERIODS=2, 8-cycle period).
module tb_pwm_breath_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_mode;
  logic       key_step;
  logic       period_end;
  logic [2:0] duty;
  logic       duty_upd;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;

  // Expected duty after each period_end in BREATH, starting at 0 with hold counter cleared.
  int br_tbl [39] = '{0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7,6,6,5,5,
                      4,4,3,3,2,2,1,1,0,0,1,1,2,2,3,3,4,4,5};

  pwm_breath_ctrl #(.DW(3), .STEP(1), .HOLD_PERIODS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_mode   (key_mode),
    .key_step   (key_step),
    .period_end (period_end),
    .duty       (duty),
    .duty_upd   (duty_upd),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: inputs applied at negedge, outputs sampled 1 time unit after posedge.
  task automatic cyc(input logic pe, input logic km, input logic ks);
    @(negedge clk);
    period_end = pe;
    key_mode   = km;
    key_step   = ks;
    @(posedge clk);
    #1;
    period_end = 1'b0;
    key_mode   = 1'b0;
    key_step   = 1'b0;
  endtask

  // One 8-cycle PWM period ending in period_end; duty must hold until the boundary.
  task automatic period(input string tag, input int d_prev, input int d_exp,
                        input int m_exp, input int u_exp);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk({tag, "_idle_upd"}, 8'(duty_upd), 8'd0);
      chk({tag, "_idle_duty"}, 8'(duty), 8'(d_prev));
    end
    cyc(1'b1, 1'b0, 1'b0);
    chk({tag, "_duty"}, 8'(duty), 8'(d_exp));
    chk({tag, "_upd"}, 8'(duty_upd), 8'(u_exp));
    chk({tag, "_mode"}, 8'(mode), 8'(m_exp));
  endtask

  initial begin
    int prev;
    int m_exp;
    rst        = 1'b1;
    key_mode   = 1'b0;
    key_step   = 1'b0;
    period_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", 8'(mode), 8'd0);
    chk("rst_duty", 8'(duty), 8'd0);
    chk("rst_upd", 8'(duty_upd), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle in OFF; key_step there is ignored.
    period("idle0", 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1);
    period("off_step", 0, 0, 0, 0);

    // MANUAL, three steps, visible only at the boundary.
    cyc(1'b0, 1'b1, 1'b0);
    chk("to_manual", 8'(mode), 8'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("step_hidden", 8'(duty), 8'd0);
    end
    period("man3", 0, 3, 1, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("man3_upd_drop", 8'(duty_upd), 8'd0);

    // Step up to 7, then one more step.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
    period("man7", 3, 7, 1, 1);
    cyc(1'b0, 1'b0, 1'b1);
`ifdef PWM_CTRL_SAT_EN
    period("man_sat", 7, 7, 1, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("man_to_down", 8'(mode), 8'd3);
    cyc(1'b0, 1'b1, 1'b0);
    chk("to_off", 8'(mode), 8'd0);
    period("off_clear", 7, 0, 0, 1);
`else
    period("man_wrap", 7, 0, 1, 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("man_to_up", 8'(mode), 8'd2);
    cyc(1'b0, 1'b1, 1'b0);
    chk("to_off", 8'(mode), 8'd0);
    period("off_clear", 0, 0, 0, 0);
`endif

    // Back to MANUAL; key_mode and key_step together: step dropped.
    cyc(1'b0, 1'b1, 1'b0);
    chk("to_manual2", 8'(mode), 8'd1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("mode_wins", 8'(mode), 8'd2);

    // Breathing: one step per two periods, reversing at 7 and at 0.
    prev = 0;
    for (int k = 1; k <= 39; k++) begin
      m_exp = (k >= 14 && k <= 27) ? 3 : 2;
      period($sformatf("br%0d", k), prev, br_tbl[k-1], m_exp,
             (br_tbl[k-1] != prev) ? 1 : 0);
      prev = br_tbl[k-1];
    end

    // Asynchronous reset between edges with duty at 5.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_duty", 8'(duty), 8'd0);
    chk("arst_mode", 8'(mode), 8'd0);
    chk("arst_upd", 8'(duty_upd), 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Resume after reset.
    cyc(1'b0, 1'b1, 1'b0);
    chk("re_manual", 8'(mode), 8'd1);
    cyc(1'b0, 1'b0, 1'b1);
    period("re_step", 0, 1, 1, 1);

    // key_mode coincident with period_end: load uses the pre-transition target.
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("co_duty", 8'(duty), 8'd2);
    chk("co_upd", 8'(duty_upd), 8'd1);
    chk("co_mode", 8'(mode), 8'd2);

    // Back-to-back period_end pulses, each handled.
    cyc(1'b1, 1'b0, 1'b0);
    chk("b2b1_duty", 8'(duty), 8'd2);
    chk("b2b1_upd", 8'(duty_upd), 8'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("b2b2_duty", 8'(duty), 8'd2);
    cyc(1'b1, 1'b0, 1'b0);
    chk("b2b3_duty", 8'(duty), 8'd3);
    chk("b2b3_upd", 8'(duty_upd), 8'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("b2b4_upd", 8'(duty_upd), 8'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("b2b5_duty", 8'(duty), 8'd4);
    chk("b2b5_upd", 8'(duty_upd), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
